// File: rtl/counter_ctrl.sv
// Run/pause/step/limit sequencer: turns button pulses into registered cnt_en/cnt_clr strobes for the counter datapath.
// Latency: one clk from decision to strobe; strobes last exactly one clk. No backpressure; buttons are single-cycle pulses.
module counter_ctrl #(
  parameter int PRESCALE = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_step,
  input  logic        btn_clear,
  input  logic [15:0] cfg_limit,
  input  logic        cfg_wrap,
  input  logic [15:0] cnt_value,
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic        running,
  output logic        done
);

  localparam int PW = $clog2(PRESCALE + 1);
  localparam logic [PW-1:0] PS_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [PW-1:0] presc, presc_d;
  logic [15:0]   limit_q;
  logic          wrap_q;
  logic          rst_pend;
  logic          en_d, clr_d;
  logic          hit;

  assign hit = (cnt_value == limit_q);

  always_comb begin
    state_d = state;
    presc_d = presc;
    en_d    = 1'b0;
    clr_d   = rst_pend;
    if (btn_clear) begin
      state_d = IDLE;
      presc_d = '0;
      clr_d   = 1'b1;
    end else begin
      unique case (state)
        IDLE, PAUSED: begin
          if (btn_start_stop) begin
            state_d = RUN;
            presc_d = '0;
          end else if (btn_step) begin
            if (!hit)        en_d    = 1'b1;
            else if (wrap_q) clr_d   = 1'b1;
            else             state_d = DONE;
          end
        end
        RUN: begin
          // A pause in the same clk as a tick swallows the tick.
          if (btn_start_stop) begin
            state_d = PAUSED;
            presc_d = '0;
          end else if (presc == PS_MAX) begin
            presc_d = '0;
            if (!hit)        en_d    = 1'b1;
            else if (wrap_q) clr_d   = 1'b1;
            else             state_d = DONE;
          end else begin
            presc_d = presc + PW'(1);
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      presc    <= '0;
      limit_q  <= '0;
      wrap_q   <= 1'b0;
      rst_pend <= 1'b1;
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b0;
      running  <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      presc    <= presc_d;
      rst_pend <= 1'b0;
      cnt_en   <= en_d;
      cnt_clr  <= clr_d;
      running  <= (state_d == RUN);
      done     <= (state_d == DONE);
      if (state == IDLE) begin
        limit_q <= cfg_limit;
        wrap_q  <= cfg_wrap;
      end
    end
  end

endmodule
